// File: rtl/viterbi_backtrace.sv
// viterbi_backtrace
//   Consumer side of the Viterbi POS tagger back-pointer path. Starting
//   from the best final state, it walks the back-pointer memory from the
//   last word down to word 0 and buffers the recovered tags. It then
//   streams them out in forward word order over a valid/ready handshake.
//
// Ports
//   i_clk, i_reset        rising-edge clock, synchronous active-high reset
//   i_start               backtrace request (accepted only while idle)
//   i_num_words           sentence length, legal 1..word_num
//   i_last_pos            best final state, sampled with i_start
//   o_bp_rd_en/word/pos   back-pointer memory read strobe and address (t,s)
//   i_bp_rd_data          predecessor of (t,s), valid one cycle after the strobe
//   o_out_valid/tag/index tag stream, i_out_ready is the downstream accept
//   o_busy                high while not idle
//   o_done                one-cycle pulse after the last tag is accepted
//   o_bp_error            sticky illegal index/length flag
//
// state     | meaning
// S_IDLE    | waiting for a start request
// S_ISSUE   | back-pointer read for (t,cur) is on the bus
// S_CAPTURE | read data returns; step cur/t down one word
// S_EMIT    | presenting path[k] until accepted
module viterbi_backtrace #(
   parameter int word_num     = 16,
   parameter int word_num_bit = 4,
   parameter int POS_num      = 11,
   parameter int POS_num_bit  = 4
) (
   input  logic                    i_clk,
   input  logic                    i_reset,
   input  logic                    i_start,
   input  logic [word_num_bit:0]   i_num_words,
   input  logic [POS_num_bit-1:0]  i_last_pos,
   output logic                    o_bp_rd_en,
   output logic [word_num_bit-1:0] o_bp_rd_word,
   output logic [POS_num_bit-1:0]  o_bp_rd_pos,
   input  logic [POS_num_bit-1:0]  i_bp_rd_data,
   output logic                    o_out_valid,
   input  logic                    i_out_ready,
   output logic [POS_num_bit-1:0]  o_out_tag,
   output logic [word_num_bit-1:0] o_out_index,
   output logic                    o_busy,
   output logic                    o_done,
   output logic                    o_bp_error
);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_ISSUE   = 2'd1,
      S_CAPTURE = 2'd2,
      S_EMIT    = 2'd3
   } state_t;

   localparam logic [word_num_bit:0]   C_WORD_MAX = (word_num_bit+1)'(word_num);
   localparam logic [POS_num_bit:0]    C_POS_LIM  = (POS_num_bit+1)'(POS_num);
   localparam logic [word_num_bit:0]   C_ONE_N    = (word_num_bit+1)'(1);
   localparam logic [word_num_bit-1:0] C_ONE_W    = word_num_bit'(1);
   localparam logic [word_num_bit-1:0] C_ZERO_W   = '0;

   state_t                  r_state;
   logic [word_num_bit:0]   r_n;
   logic [word_num_bit-1:0] r_t;
   logic [word_num_bit-1:0] r_k;
   logic [POS_num_bit-1:0]  r_cur;
   logic [POS_num_bit-1:0]  r_path [word_num];

   logic                    r_bp_rd_en;
   logic [word_num_bit-1:0] r_bp_rd_word;
   logic [POS_num_bit-1:0]  r_bp_rd_pos;
   logic                    r_out_valid;
   logic [POS_num_bit-1:0]  r_out_tag;
   logic [word_num_bit-1:0] r_out_index;
   logic                    r_busy;
   logic                    r_done;
   logic                    r_bp_error;

   logic                    w_len_ok;
   logic                    w_last_ok;
   logic [POS_num_bit-1:0]  w_last_cur;
   logic                    w_d_ok;
   logic [POS_num_bit-1:0]  w_d;
   logic [word_num_bit:0]   w_n_m1;
   logic [word_num_bit-1:0] w_t0;
   logic [word_num_bit-1:0] w_t_m1;
   logic [word_num_bit-1:0] w_k_p1;
   logic                    w_k_last;

   assign w_len_ok   = (i_num_words != '0) && (i_num_words <= C_WORD_MAX);
   assign w_last_ok  = ({1'b0, i_last_pos} < C_POS_LIM);
   assign w_last_cur = w_last_ok ? i_last_pos : '0;
   assign w_d_ok     = ({1'b0, i_bp_rd_data} < C_POS_LIM);
   assign w_d        = w_d_ok ? i_bp_rd_data : '0;
   assign w_n_m1     = i_num_words - C_ONE_N;
   assign w_t0       = w_n_m1[word_num_bit-1:0];
   assign w_t_m1     = r_t - C_ONE_W;
   assign w_k_p1     = r_k + C_ONE_W;
   assign w_k_last   = ({1'b0, r_k} == (r_n - C_ONE_N));

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state      <= S_IDLE;
         r_n          <= '0;
         r_t          <= '0;
         r_k          <= '0;
         r_cur        <= '0;
         for (int i = 0; i < word_num; i++) r_path[i] <= '0;
         r_bp_rd_en   <= 1'b0;
         r_bp_rd_word <= '0;
         r_bp_rd_pos  <= '0;
         r_out_valid  <= 1'b0;
         r_out_tag    <= '0;
         r_out_index  <= '0;
         r_busy       <= 1'b0;
         r_done       <= 1'b0;
         r_bp_error   <= 1'b0;
      end else begin
         // read strobe and address are only ever asserted for the single ISSUE cycle
         r_done       <= 1'b0;
         r_bp_rd_en   <= 1'b0;
         r_bp_rd_word <= '0;
         r_bp_rd_pos  <= '0;
         case (r_state)
            S_IDLE: begin
               if (i_start) begin
                  if (w_len_ok) begin
                     r_n          <= i_num_words;
                     r_t          <= w_t0;
                     r_k          <= '0;
                     r_cur        <= w_last_cur;
                     r_path[w_t0] <= w_last_cur;
                     r_bp_error   <= ~w_last_ok;
                     r_busy       <= 1'b1;
                     if (w_t0 == C_ZERO_W) begin
                        r_state     <= S_EMIT;
                        r_out_valid <= 1'b1;
                        r_out_index <= '0;
                        r_out_tag   <= w_last_cur;
                     end else begin
                        r_state      <= S_ISSUE;
                        r_bp_rd_en   <= 1'b1;
                        r_bp_rd_word <= w_t0;
                        r_bp_rd_pos  <= w_last_cur;
                     end
                  end else begin
                     r_bp_error <= 1'b1;
                  end
               end
            end
            S_ISSUE: begin
               r_state <= S_CAPTURE;
            end
            S_CAPTURE: begin
               r_cur          <= w_d;
               r_path[w_t_m1] <= w_d;
               r_t            <= w_t_m1;
               if (!w_d_ok) r_bp_error <= 1'b1;
               if (w_t_m1 == C_ZERO_W) begin
                  // path[0] is being written this edge, so forward it straight to the output
                  r_state     <= S_EMIT;
                  r_out_valid <= 1'b1;
                  r_out_index <= '0;
                  r_out_tag   <= w_d;
               end else begin
                  r_state      <= S_ISSUE;
                  r_bp_rd_en   <= 1'b1;
                  r_bp_rd_word <= w_t_m1;
                  r_bp_rd_pos  <= w_d;
               end
            end
            S_EMIT: begin
               if (i_out_ready) begin
                  if (w_k_last) begin
                     r_state     <= S_IDLE;
                     r_out_valid <= 1'b0;
                     r_out_index <= '0;
                     r_out_tag   <= '0;
                     r_busy      <= 1'b0;
                     r_done      <= 1'b1;
                  end else begin
                     r_k         <= w_k_p1;
                     r_out_index <= w_k_p1;
                     r_out_tag   <= r_path[w_k_p1];
                  end
               end
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign o_bp_rd_en   = r_bp_rd_en;
   assign o_bp_rd_word = r_bp_rd_word;
   assign o_bp_rd_pos  = r_bp_rd_pos;
   assign o_out_valid  = r_out_valid;
   assign o_out_tag    = r_out_tag;
   assign o_out_index  = r_out_index;
   assign o_busy       = r_busy;
   assign o_done       = r_done;
   assign o_bp_error   = r_bp_error;

endmodule

// File: tb/tb_viterbi_backtrace.sv
// Bench for viterbi_backtrace: back-pointer memory model with one-cycle
// read latency, reference path model feeding expected read-address and
// tag queues, and a negedge monitor that pops and compares them.
module tb_viterbi_backtrace;

   logic       i_clk = 1'b0;
   logic       i_reset;
   logic       i_start;
   logic [4:0] i_num_words;
   logic [3:0] i_last_pos;
   logic       o_bp_rd_en;
   logic [3:0] o_bp_rd_word;
   logic [3:0] o_bp_rd_pos;
   logic [3:0] i_bp_rd_data;
   logic       o_out_valid;
   logic       i_out_ready;
   logic [3:0] o_out_tag;
   logic [3:0] o_out_index;
   logic       o_busy;
   logic       o_done;
   logic       o_bp_error;

   always #5 i_clk = ~i_clk;

   viterbi_backtrace dut (
      .i_clk        (i_clk),
      .i_reset      (i_reset),
      .i_start      (i_start),
      .i_num_words  (i_num_words),
      .i_last_pos   (i_last_pos),
      .o_bp_rd_en   (o_bp_rd_en),
      .o_bp_rd_word (o_bp_rd_word),
      .o_bp_rd_pos  (o_bp_rd_pos),
      .i_bp_rd_data (i_bp_rd_data),
      .o_out_valid  (o_out_valid),
      .i_out_ready  (i_out_ready),
      .o_out_tag    (o_out_tag),
      .o_out_index  (o_out_index),
      .o_busy       (o_busy),
      .o_done       (o_done),
      .o_bp_error   (o_bp_error)
   );

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string tag, input int got, input int exp);
      n_tests++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   logic [3:0] bp_mem [16][16];
   int         cyc = 0;
   bit         mon_on = 1'b0;
   bit         rdy_toggle = 1'b0;
   bit         rdy_level = 1'b1;
   logic [3:0] rdy_pat = 4'b1001;
   int         rd_cnt, busy_cnt, done_cnt, acc_cnt, first_valid;
   bit         stall_pending;
   int         stall_val;
   bit         exp_err;
   int         exp_rd[$];
   int         exp_tag[$];

   initial forever begin
      @(posedge i_clk);
      cyc++;
   end

   // back-pointer memory: registered read, data valid the cycle after the strobe
   initial begin
      bit         pend;
      logic [3:0] aw, ap;
      i_bp_rd_data = '0;
      forever begin
         @(negedge i_clk);
         pend = o_bp_rd_en;
         aw   = o_bp_rd_word;
         ap   = o_bp_rd_pos;
         @(posedge i_clk);
         #1;
         if (pend) i_bp_rd_data = bp_mem[aw][ap];
         else      i_bp_rd_data = 4'($urandom);
      end
   end

   initial begin
      int ph = 0;
      i_out_ready = 1'b1;
      forever begin
         @(posedge i_clk);
         #1;
         if (rdy_toggle) begin
            i_out_ready = rdy_pat[ph];
            ph = (ph + 1) % 4;
         end else begin
            i_out_ready = rdy_level;
         end
      end
   end

   initial forever begin
      @(negedge i_clk);
      if (mon_on) begin
         if (o_bp_rd_en) begin
            rd_cnt++;
            if (exp_rd.size() == 0) check("rd_extra", 1, 0);
            else check("rd_addr", int'({o_bp_rd_word, o_bp_rd_pos}), exp_rd.pop_front());
         end else begin
            check("rd_idle_addr", int'({o_bp_rd_word, o_bp_rd_pos}), 0);
         end
         if (o_busy) busy_cnt++;
         if (o_done) done_cnt++;
         if (o_out_valid) begin
            if (first_valid < 0) first_valid = cyc;
            if (stall_pending) check("stall_hold", int'({o_out_index, o_out_tag}), stall_val);
            if (i_out_ready) begin
               acc_cnt++;
               stall_pending = 1'b0;
               if (exp_tag.size() == 0) check("tag_extra", 1, 0);
               else check("tag", int'({o_out_index, o_out_tag}), exp_tag.pop_front());
            end else begin
               stall_pending = 1'b1;
               stall_val     = int'({o_out_index, o_out_tag});
            end
         end else begin
            stall_pending = 1'b0;
         end
      end
   end

   task automatic clear_counts();
      rd_cnt = 0; busy_cnt = 0; done_cnt = 0; acc_cnt = 0;
      first_valid = -1; stall_pending = 1'b0;
      exp_rd.delete(); exp_tag.delete();
   endtask

   task automatic build_expect(input int n, input int last);
      int path [16];
      int cur, d;
      exp_err = (last >= 11);
      cur = (last >= 11) ? 0 : last;
      path[n-1] = cur;
      for (int t = n - 1; t >= 1; t--) begin
         exp_rd.push_back((t << 4) | cur);
         d = int'(bp_mem[t][cur]);
         if (d >= 11) begin
            exp_err = 1'b1;
            d = 0;
         end
         path[t-1] = d;
         cur = d;
      end
      for (int k = 0; k < n; k++) exp_tag.push_back((k << 4) | path[k]);
   endtask

   task automatic fill_mem();
      for (int t = 0; t < 16; t++)
         for (int s = 0; s < 16; s++)
            bp_mem[t][s] = 4'($urandom_range(0, 10));
   endtask

   int acc_cyc;

   task automatic drive_start(input int n, input int last);
      @(posedge i_clk);
      #1;
      i_start     = 1'b1;
      i_num_words = 5'(n);
      i_last_pos  = 4'(last);
      @(posedge i_clk);
      #1;
      acc_cyc = cyc;
      i_start = 1'b0;
   endtask

   task automatic run_req(input int n, input int last, input bit toggle);
      clear_counts();
      rdy_toggle = toggle;
      rdy_level  = 1'b1;
      build_expect(n, last);
      drive_start(n, last);
      for (int i = 0; i < 500 && done_cnt == 0; i++) @(negedge i_clk);
      if (done_cnt == 0) check("done_timeout", 0, 1);
      repeat (3) @(posedge i_clk);
      #1;
      rdy_toggle = 1'b0;
      check("done_pulses", done_cnt, 1);
      check("rd_count", rd_cnt, n - 1);
      check("rd_left", exp_rd.size(), 0);
      check("tag_left", exp_tag.size(), 0);
      check("emit_latency", first_valid - acc_cyc, 2 * (n - 1));
      check("bp_error", int'(o_bp_error), int'(exp_err));
      check("busy_after", int'(o_busy), 0);
      if (!toggle) check("busy_cycles", busy_cnt, 2 * (n - 1) + n);
   endtask

   task automatic bad_len(input int n);
      clear_counts();
      drive_start(n, 2);
      repeat (5) @(posedge i_clk);
      #1;
      check("badlen_err", int'(o_bp_error), 1);
      check("badlen_busy", busy_cnt, 0);
      check("badlen_rd", rd_cnt, 0);
      check("badlen_done", done_cnt, 0);
   endtask

   function automatic int all_outs();
      return int'({o_bp_rd_en, o_bp_rd_word, o_bp_rd_pos, o_out_valid, o_out_tag,
                   o_out_index, o_busy, o_done, o_bp_error});
   endfunction

   task automatic abort_test(input bit in_emit);
      bit hit = 1'b0;
      clear_counts();
      rdy_level = 1'b1;
      build_expect(16, 6);
      drive_start(16, 6);
      for (int i = 0; i < 200 && !hit; i++) begin
         @(negedge i_clk);
         hit = in_emit ? (acc_cnt == 2) : o_bp_rd_en;
      end
      if (!hit) check("abort_reach", 0, 1);
      @(posedge i_clk);
      #1;
      i_reset = 1'b1;
      @(posedge i_clk);
      #1;
      i_reset = 1'b0;
      check(in_emit ? "abort_emit_outs" : "abort_cap_outs", all_outs(), 0);
      exp_rd.delete();
      exp_tag.delete();
      done_cnt = 0;
      repeat (4) @(posedge i_clk);
      #1;
      check("abort_no_done", done_cnt, 0);
      check("abort_idle", int'(o_busy), 0);
   endtask

   initial begin
      i_reset = 1'b1;
      i_start = 1'b0;
      i_num_words = '0;
      i_last_pos = '0;
      fill_mem();
      clear_counts();
      repeat (3) @(posedge i_clk);
      #1;
      check("reset_outs", all_outs(), 0);
      i_reset = 1'b0;
      mon_on = 1'b1;

      bp_mem[3][7] = 4'd2; bp_mem[2][2] = 4'd10; bp_mem[1][10] = 4'd5;
      run_req(4, 7, 1'b0);

      run_req(1, 4, 1'b0);

      fill_mem();
      run_req(16, $urandom_range(0, 10), 1'b1);

      bp_mem[2][3] = 4'd13; bp_mem[1][0] = 4'd6;
      run_req(3, 3, 1'b0);
      run_req(2, 5, 1'b0);
      run_req(2, 12, 1'b0);

      run_req(5, 9, 1'b0);
      bad_len(0);
      bad_len(17);

      fill_mem();
      abort_test(1'b0);
      run_req(5, 1, 1'b0);
      abort_test(1'b1);
      run_req(6, 10, 1'b1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/viterbi_backtrace.md
Name: viterbi_backtrace

Overview:
- Consumer side of the back-pointer path in the Viterbi POS tagger.
- The forward pass stores, for each word position t and each POS state s, the 4-bit predecessor index chosen by the max stage. It also registers the final best state as last_POS.
- This block starts from last_POS, walks the back-pointer memory from the last word down to word 0, and buffers the recovered tag path.
- It then streams the tags out in forward word order over a valid/ready interface.

Parameters:
- word_num, 16, maximum sentence length in words.
- word_num_bit, 4, width of a word index.
- POS_num, 11, number of POS states; legal tag values are 0..POS_num-1.
- POS_num_bit, 4, width of a POS index.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request a backtrace; accepted only in IDLE.
- num_words  input  word_num_bit+1  sentence length for this request; legal range 1..word_num.
- last_POS  input  POS_num_bit  best final state; sampled together with start.
- bp_rd_en  output  1  back-pointer memory read strobe.
- bp_rd_word  output  word_num_bit  word index t of the read.
- bp_rd_pos  output  POS_num_bit  state index s of the read.
- bp_rd_data  input  POS_num_bit  predecessor of (t,s); valid exactly 1 cycle after bp_rd_en.
- out_valid  output  1  out_tag and out_index are valid.
- out_ready  input  1  downstream accepts the current tag.
- out_tag  output  POS_num_bit  recovered tag.
- out_index  output  word_num_bit  word position of out_tag.
- busy  output  1  high whenever the FSM is not in IDLE.
- done  output  1  one-cycle pulse after the last tag is accepted.
- bp_error  output  1  sticky flag for an illegal index or length.

Behaviour:
- Reset (synchronous): FSM goes to IDLE. All outputs are 0. Internal counters and the path buffer are cleared. Reset has priority in every state, including mid-backtrace and mid-emit; the aborted request is discarded and no done pulse is issued.
- Internal registers:
  - n: latched num_words.
  - t: current word index.
  - cur: current state.
  - k: emit counter.
  - path[0..word_num-1]: POS_num_bit each.
- IDLE:
  - start=1 with num_words in 1..word_num:
    - Latch n. Set t=n-1. Set cur = last_POS, or 0 if last_POS>=POS_num; in that case set bp_error.
    - Write path[n-1] = cur. Clear bp_error unless this start sets it.
    - Go to EMIT if n==1, otherwise to ISSUE.
  - start=1 with num_words==0 or >word_num: set bp_error, stay in IDLE, and do not pulse done.
- ISSUE (1 cycle): bp_rd_en=1, bp_rd_word=t, bp_rd_pos=cur. Go to CAPTURE.
- CAPTURE (1 cycle, bp_rd_en=0):
  - d = bp_rd_data. If d>=POS_num, set bp_error and use d=0.
  - cur<=d, path[t-1]<=d, t<=t-1.
  - Go to EMIT if t-1==0, otherwise to ISSUE.
- Backtrace latency: 2*(n-1) cycles after the start-accept edge, the FSM enters EMIT. Exactly n-1 memory reads are issued, in strictly descending t.
- EMIT:
  - out_valid=1, out_index=k, out_tag=path[k], with k starting at 0.
  - out_tag and out_index hold stable while out_valid=1 and out_ready=0.
  - On out_valid&out_ready: if k==n-1, go to IDLE and pulse done for the next cycle; otherwise k<=k+1.
  - Back-to-back acceptance gives one tag per cycle.
- start is ignored whenever busy=1.
- When bp_rd_en=0, bp_rd_word and bp_rd_pos are 0.
- bp_error is sticky until the next legal start or reset.

Test Plan:
- n=4, last_POS=7, bp[3][7]=2, bp[2][2]=10, bp[1][10]=5, out_ready=1 -> reads issued at (3,7),(2,2),(1,10); tags 5,10,2,7 emitted at indices 0..3; done pulses once; busy is high for 2*3+4 cycles.
- n=1, last_POS=4 -> no bp_rd_en; a single tag 4 at index 0 on the cycle after start; done follows.
- n=16, random back-pointers with out_ready toggling 1,0,0,1 -> 15 reads; all 16 tags match the reference path in order; out_tag is stable during stalls.
- bp[2][3]=13 with n=3, last_POS=3 -> bp_error=1; path[1]=0; backtrace continues from state 0; bp_error clears on the next legal start.
- num_words=0, then num_words=17 -> bp_error=1, busy stays 0, no reads, no done.
- Reset asserted in CAPTURE, and separately in EMIT after 2 tags -> the next cycle has all outputs 0 and the FSM in IDLE; a new start then runs correctly.
